// File: rtl/line_mem_responder.sv
// Line-organised memory responder for the 128-bit cache miss/write-back interface.
// Optional read/write statistics counters are enabled by defining MEM_STATS_EN.
module line_mem_responder #(
   parameter int unsigned DEPTH   = 256,
   parameter int unsigned IDX_W   = 8,
   parameter int unsigned LATENCY = 4
) (
   input  logic         clk,
   input  logic         proc_reset_n,
   input  logic         mem_read,
   input  logic         mem_write,
   input  logic [27:0]  mem_addr,
   input  logic [127:0] mem_wdata,
   output logic [127:0] mem_rdata,
   output logic         mem_ready
`ifdef MEM_STATS_EN
   ,
   output logic [15:0]  rd_count,
   output logic [15:0]  wr_count
`endif
);

   typedef enum logic [1:0] {StIdle, StWait, StResp, StHold} state_e;

   state_e             state_q;
   logic [7:0]         cnt_q;
   logic               op_wr_q;
   logic [IDX_W-1:0]   idx_q;
   logic [127:0]       wdata_q;
   logic [127:0]       mem_q [DEPTH];

   logic [IDX_W-1:0]   req_idx;
   logic               req_any;
   logic               commit_wr;

   // Upper address bits alias onto the same lines.
   logic               unused_addr;
   assign unused_addr = ^mem_addr[27:IDX_W];

   assign req_idx   = mem_addr[IDX_W-1:0];
   assign req_any   = mem_read | mem_write;
   assign commit_wr = proc_reset_n & (state_q == StResp) & op_wr_q;

   // Storage is never reset; a write commits on the edge leaving RESP.
   always_ff @(posedge clk) begin
      if (commit_wr) begin
         mem_q[idx_q] <= wdata_q;
      end
   end

   always_ff @(posedge clk) begin
      if (!proc_reset_n) begin
         state_q   <= StIdle;
         cnt_q     <= 8'd0;
         op_wr_q   <= 1'b0;
         idx_q     <= '0;
         wdata_q   <= '0;
         mem_ready <= 1'b0;
         mem_rdata <= '0;
      end else begin
         mem_ready <= 1'b0;
         case (state_q)
            StIdle: begin
               if (req_any) begin
                  // Write wins when both requests are raised together.
                  op_wr_q <= mem_write;
                  idx_q   <= req_idx;
                  wdata_q <= mem_wdata;
                  cnt_q   <= 8'(LATENCY - 1);
                  if (LATENCY == 1) begin
                     state_q   <= StResp;
                     mem_ready <= 1'b1;
                     mem_rdata <= mem_write ? '0 : mem_q[req_idx];
                  end else begin
                     state_q <= StWait;
                  end
               end
            end
            StWait: begin
               cnt_q <= cnt_q - 8'd1;
               if (cnt_q == 8'd1) begin
                  state_q   <= StResp;
                  mem_ready <= 1'b1;
                  mem_rdata <= op_wr_q ? '0 : mem_q[idx_q];
               end
            end
            StResp: begin
               state_q <= StHold;
            end
            StHold: begin
               // Dead cycle so the initiator's stale request is not re-accepted.
               state_q <= StIdle;
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

`ifdef MEM_STATS_EN
   always_ff @(posedge clk) begin
      if (!proc_reset_n) begin
         rd_count <= 16'd0;
         wr_count <= 16'd0;
      end else if (state_q == StResp) begin
         if (op_wr_q) begin
            if (wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
         end else begin
            if (rd_count != 16'hFFFF) rd_count <= rd_count + 16'd1;
         end
      end
   end
`endif

   // Simultaneous read and write while idle is an initiator protocol error.
   proto_err_both_req: cover property (@(posedge clk) disable iff (!proc_reset_n)
      (state_q == StIdle) && mem_read && mem_write);

endmodule

// File: tb/tb_line_mem_responder.sv
// Table-driven, scoreboarded bench for line_mem_responder (default LATENCY=4, DEPTH=256).
module tb_line_mem_responder;

   localparam int unsigned LAT = 4;

   logic         clk = 1'b0;
   logic         proc_reset_n;
   logic         mem_read;
   logic         mem_write;
   logic [27:0]  mem_addr;
   logic [127:0] mem_wdata;
   logic [127:0] mem_rdata;
   logic         mem_ready;
`ifdef MEM_STATS_EN
   logic [15:0]  rd_count;
   logic [15:0]  wr_count;
`endif

   always #5 clk = ~clk;

   line_mem_responder #(
      .DEPTH   (256),
      .IDX_W   (8),
      .LATENCY (LAT)
   ) dut (
      .clk          (clk),
      .proc_reset_n (proc_reset_n),
      .mem_read     (mem_read),
      .mem_write    (mem_write),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .mem_rdata    (mem_rdata),
      .mem_ready    (mem_ready)
`ifdef MEM_STATS_EN
      ,
      .rd_count     (rd_count),
      .wr_count     (wr_count)
`endif
   );

   typedef struct {
      bit           wr;
      bit           rd;
      logic [27:0]  addr;
      logic [127:0] wdata;
      int           stale;
      logic [127:0] exp;
   } vec_t;

   typedef struct {
      bit           is_rd;
      logic [127:0] data;
   } sb_t;

   localparam int NVEC = 13;
   vec_t vecs [NVEC];
   sb_t  sb_q [$];

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic wait_ready(output int n, output bit ok);
      n  = 0;
      ok = 1'b0;
      while (!ok && n < 50) begin
         @(negedge clk);
         n++;
         if (mem_ready) ok = 1'b1;
      end
   endtask

   task automatic score(input string name);
      sb_t e;
      if (sb_q.size() == 0) begin
         n_cmp++;
         n_err++;
         $display("FAIL %s: ready with empty scoreboard got 1 expected 0", name);
      end else begin
         e = sb_q.pop_front();
         if (e.is_rd) check({name, " rdata"}, mem_rdata, e.data);
      end
   endtask

   task automatic run_req(input bit wr, input bit rd, input logic [27:0] addr,
                          input logic [127:0] wd, input int stale,
                          input logic [127:0] exp, input string name);
      sb_t e;
      int  n;
      bit  ok;
      e.is_rd = rd && !wr;
      e.data  = exp;
      sb_q.push_back(e);
      @(negedge clk);
      mem_write = wr;
      mem_read  = rd;
      mem_addr  = addr;
      mem_wdata = wd;
      wait_ready(n, ok);
      if (!ok) begin
         n_cmp++;
         n_err++;
         $display("FAIL %s timeout: got no ready expected ready", name);
         void'(sb_q.pop_front());
         mem_write = 1'b0;
         mem_read  = 1'b0;
         return;
      end
      check({name, " latency"}, 128'(n), 128'(LAT));
      score(name);
      for (int i = 0; i < stale; i++) begin
         @(negedge clk);
         check({name, " stale ready"}, 128'(mem_ready), 128'd0);
      end
      mem_write = 1'b0;
      mem_read  = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check({name, " pulse width"}, 128'(mem_ready), 128'd0);
      end
   endtask

   initial begin
      logic [15:0] rd0, wr0;
      int  n;
      bit  ok;
      sb_t e;

      vecs[0]  = '{1'b1, 1'b0, 28'h0000012, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 0, '0};
      vecs[1]  = '{1'b0, 1'b1, 28'h0000012, '0, 0, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210};
      vecs[2]  = '{1'b1, 1'b0, 28'h0000105, {16{8'hAA}}, 0, '0};
      vecs[3]  = '{1'b0, 1'b1, 28'h0000005, '0, 1, {16{8'hAA}}};
      vecs[4]  = '{1'b1, 1'b1, 28'h0000003, 128'h5, 0, '0};
      vecs[5]  = '{1'b0, 1'b1, 28'h0000003, '0, 0, 128'h5};
      vecs[6]  = '{1'b1, 1'b0, 28'h0000007, 128'h0, 0, '0};
      vecs[7]  = '{1'b0, 1'b1, 28'h0000007, '0, 0, 128'h0};
      vecs[8]  = '{1'b1, 1'b0, 28'hFFFFFFF, 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555, 0, '0};
      vecs[9]  = '{1'b0, 1'b1, 28'h00000FF, '0, 1, 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555};
      vecs[10] = '{1'b0, 1'b1, 28'h0000012, '0, 0, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210};
      vecs[11] = '{1'b1, 1'b0, 28'h0000012, 128'hFEDC_BA98_7654_3210_0123_4567_89AB_CDEF, 0, '0};
      vecs[12] = '{1'b0, 1'b1, 28'h0000012, '0, 0, 128'hFEDC_BA98_7654_3210_0123_4567_89AB_CDEF};

      proc_reset_n = 1'b0;
      mem_read     = 1'b0;
      mem_write    = 1'b0;
      mem_addr     = '0;
      mem_wdata    = '0;
      repeat (2) @(negedge clk);
      proc_reset_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("idle ready", 128'(mem_ready), 128'd0);
         check("idle rdata", mem_rdata, 128'd0);
      end

      rd0 = '0;
      wr0 = '0;
      for (int i = 0; i < NVEC; i++) begin
`ifdef MEM_STATS_EN
         if (i == 4) begin
            rd0 = rd_count;
            wr0 = wr_count;
         end
`endif
         run_req(vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].wdata, vecs[i].stale,
                 vecs[i].exp, $sformatf("vec%0d", i));
`ifdef MEM_STATS_EN
         if (i == 5) begin
            check("stats wr_count", 128'(wr_count), 128'(wr0 + 16'd1));
            check("stats rd_count", 128'(rd_count), 128'(rd0 + 16'd1));
         end
`endif
      end

      // Back-to-back: request held continuously, second accepted only after HOLD.
      e.is_rd = 1'b1;
      e.data  = 128'hFEDC_BA98_7654_3210_0123_4567_89AB_CDEF;
      sb_q.push_back(e);
      sb_q.push_back(e);
      @(negedge clk);
      mem_read = 1'b1;
      mem_addr = 28'h0000012;
      wait_ready(n, ok);
      check("b2b first ready seen", 128'(ok), 128'd1);
      check("b2b first latency", 128'(n), 128'(LAT));
      if (ok) score("b2b first");
      wait_ready(n, ok);
      check("b2b second ready seen", 128'(ok), 128'd1);
      check("b2b interval", 128'(n), 128'(LAT + 2));
      if (ok) score("b2b second");
      mem_read = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("b2b tail ready", 128'(mem_ready), 128'd0);
      end
      while (sb_q.size() != 0) void'(sb_q.pop_front());

      // Reset during WAIT of a write abandons it.
      @(negedge clk);
      mem_write = 1'b1;
      mem_addr  = 28'h0000007;
      mem_wdata = {128{1'b1}};
      repeat (2) @(negedge clk);
      proc_reset_n = 1'b0;
      mem_write    = 1'b0;
      repeat (2) @(negedge clk);
      proc_reset_n = 1'b1;
      for (int i = 0; i < 2 * LAT; i++) begin
         @(negedge clk);
         check("abandoned write ready", 128'(mem_ready), 128'd0);
      end
      run_req(1'b0, 1'b1, 28'h0000007, '0, 0, 128'h0, "read after abandon");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
